// File: rtl/cic_comp_fir.sv
// CIC droop-compensation FIR: one shared multiplier walks all taps per output,
// with optional extra decimation and a valid/ready output register.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an input sample; coefficient writes allowed
// MAC   | one tap per cycle, accumulating x[n-k]*h[k]
// RND   | round, saturate and register the result
// HOLD  | result presented until the consumer accepts it
module cic_comp_fir #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_TAPS   = 15,
  parameter int COEF_WIDTH = 16,
  parameter int COEF_FRAC  = 14,
  parameter int ACC_WIDTH  = 40,
  parameter int DECIM      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_valid,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        coef_we,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_addr,
  input  logic [COEF_WIDTH-1:0]       coef_wdata,
  output logic                        overrun,
  input  logic                        overrun_clr
);

  localparam int AW    = $clog2(NUM_TAPS);
  localparam int PW    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PRODW = DATA_WIDTH + COEF_WIDTH;

  localparam logic [COEF_WIDTH-1:0] COEF_ONE = COEF_WIDTH'(1) << COEF_FRAC;
  localparam logic signed [ACC_WIDTH-1:0] RND_HALF = ACC_WIDTH'(1) << (COEF_FRAC - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, RND, HOLD} state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] hist [NUM_TAPS];
  logic [COEF_WIDTH-1:0] coef [NUM_TAPS];
  logic [AW-1:0]         wr_ptr, wr_nxt;
  logic [AW-1:0]         rd_ptr, rd_nxt;
  logic [AW-1:0]         tap_k;
  logic [PW-1:0]         phase;
  logic signed [ACC_WIDTH-1:0] acc;

  logic accept, drop, coef_wr, mac_en, rnd_en, start_mac, phase_last, addr_ok;

  logic [DATA_WIDTH-1:0]        x_tap;
  logic [COEF_WIDTH-1:0]        h_tap;
  logic signed [PRODW-1:0]      prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, acc_rnd, acc_shr;
  logic [DATA_WIDTH-1:0]        sat_data;

  assign addr_ok    = ({{(32-AW){1'b0}}, coef_addr} < 32'(NUM_TAPS));
  assign phase_last = (phase == PW'(DECIM - 1));
  assign start_mac  = accept && phase_last;
  assign wr_nxt     = (wr_ptr == AW'(NUM_TAPS - 1)) ? '0 : wr_ptr + 1'b1;
  assign rd_nxt     = (rd_ptr == AW'(NUM_TAPS - 1)) ? '0 : rd_ptr + 1'b1;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_mac) state_nxt = MAC;
      MAC:     if (tap_k == '0) state_nxt = RND;
      RND:     state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state decode
  always_comb begin
    accept  = 1'b0;
    coef_wr = 1'b0;
    mac_en  = 1'b0;
    rnd_en  = 1'b0;
    case (state)
      IDLE: begin
        accept  = in_valid;
        coef_wr = coef_we && addr_ok;
      end
      MAC:     mac_en = 1'b1;
      RND:     rnd_en = 1'b1;
      default: ;
    endcase
    drop = in_valid && (state != IDLE);
  end

  // Taps are walked oldest-first: tap_k counts down from NUM_TAPS-1 while
  // rd_ptr climbs from the slot just after the newest sample.
  assign x_tap    = hist[rd_ptr];
  assign h_tap    = coef[tap_k];
  assign prod     = $signed({{COEF_WIDTH{x_tap[DATA_WIDTH-1]}}, x_tap}) *
                    $signed({{DATA_WIDTH{h_tap[COEF_WIDTH-1]}}, h_tap});
  assign prod_ext = {{(ACC_WIDTH-PRODW){prod[PRODW-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        hist[i] <= '0;
        coef[i] <= (i == 0) ? COEF_ONE : '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      tap_k  <= '0;
      phase  <= '0;
      acc    <= '0;
    end else begin
      // the write lands before any MAC started in the same cycle reads it
      if (coef_wr) coef[coef_addr] <= coef_wdata;
      if (accept) begin
        hist[wr_ptr] <= in_data;
        wr_ptr       <= wr_nxt;
        if (phase_last) begin
          phase  <= '0;
          acc    <= '0;
          rd_ptr <= wr_nxt;
          tap_k  <= AW'(NUM_TAPS - 1);
        end else begin
          phase <= phase + 1'b1;
        end
      end
      if (mac_en) begin
        acc    <= acc + prod_ext;
        rd_ptr <= rd_nxt;
        tap_k  <= tap_k - 1'b1;
      end
    end
  end

  assign acc_rnd = acc + RND_HALF;
  assign acc_shr = acc_rnd >>> COEF_FRAC;

  always_comb begin
    if (acc_shr > SAT_MAX)      sat_data = SAT_MAX[DATA_WIDTH-1:0];
    else if (acc_shr < SAT_MIN) sat_data = SAT_MIN[DATA_WIDTH-1:0];
    else                        sat_data = acc_shr[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rnd_en) begin
        out_data  <= sat_data;
        out_valid <= 1'b1;
      end else if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: two instances (DECIM=1 and DECIM=2) share stimulus;
// a queue of expected samples is popped on every selected output handshake.
module tb_cic_comp_fir;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        out_ready;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        overrun_clr;

  logic [15:0] out_data1, out_data2;
  logic        out_valid1, out_valid2;
  logic        overrun1, overrun2;

  always #5 clk = ~clk;

  cic_comp_fir #(.DECIM(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .overrun(overrun1), .overrun_clr(overrun_clr)
  );

  cic_comp_fir #(.DECIM(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .overrun(overrun2), .overrun_clr(overrun_clr)
  );

  typedef struct {
    logic [15:0] din;
    logic [15:0] exp;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          sel = 1;
  logic [15:0] sb_q[$];
  vec_t        tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // scoreboard: one pop per handshake on the selected instance
  always @(negedge clk) begin
    if (!rst) begin
      if ((sel == 1 && out_valid1 && out_ready) || (sel == 2 && out_valid2 && out_ready)) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_output", (sel == 1) ? out_data1 : out_data2, 32'hFFFF_FFFF);
        end else begin
          check("sb_out", (sel == 1) ? out_data1 : out_data2, sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic send(input logic [15:0] d);
    @(posedge clk); #1;
    in_data  = d;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wcoef(input logic [3:0] a, input logic [15:0] v);
    @(posedge clk); #1;
    coef_we    = 1'b1;
    coef_addr  = a;
    coef_wdata = v;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < 80) begin
      @(posedge clk);
      n++;
    end
    check({name, "_drain_pending"}, sb_q.size(), 0);
    sb_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    sb_q.push_back(v.exp);
    send(v.din);
    wait_drain(name);
  endtask

  initial begin
    int lat;
    int n;
    logic seen;

    rst = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0; overrun_clr = 1'b0;
    do_reset();

    check("rst_out_data1", out_data1, 0);
    check("rst_out_valid1", out_valid1, 0);
    check("rst_overrun1", overrun1, 0);
    check("rst_out_data2", out_data2, 0);
    check("rst_out_valid2", out_valid2, 0);
    check("rst_overrun2", overrun2, 0);

    // DECIM=2 with identity coefficients: only the second sample produces output
    sel = 2;
    send(16'd100);
    seen = 1'b0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (out_valid2) seen = 1'b1;
    end
    check("t1_no_out_first", seen, 0);
    sb_q.push_back(16'd200);
    @(posedge clk); #1;
    in_data = 16'd200; in_valid = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid2) break;
    end
    check("t1_latency", lat, 17);
    wait_drain("t1");
    check("t1_overrun", overrun2, 0);
    repeat (30) @(posedge clk);
    #1 check("t1_single_output", out_valid2, 0);

    // impulse through ramped coefficients
    sel = 1;
    do_reset();
    for (int k = 0; k < 15; k++) wcoef(4'(k), 16'(16'h0100 * (k + 1)));
    tbl.delete();
    tbl.push_back('{din: 16'h4000, exp: 16'h0100});
    for (int k = 1; k < 15; k++) tbl.push_back('{din: 16'h0000, exp: 16'(16'h0100 * (k + 1))});
    tbl.push_back('{din: 16'h0000, exp: 16'h0000});
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("t2_imp%0d", i));

    // saturation with all taps at 1.0
    do_reset();
    for (int k = 0; k < 15; k++) wcoef(4'(k), 16'h4000);
    tbl.delete();
    for (int i = 0; i < 15; i++) tbl.push_back('{din: 16'h7FFF, exp: 16'h7FFF});
    for (int m = 1; m <= 15; m++)
      tbl.push_back('{din: 16'h8000, exp: (m <= 6) ? 16'h7FFF : (m == 7) ? 16'h7FF8 : 16'h8000});
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("t3_sat%0d", i));

    // rounding: h[0]=0.5 written in the same cycle as the first sample
    do_reset();
    sb_q.push_back(16'd2);
    @(posedge clk); #1;
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'h2000;
    in_data = 16'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0; in_valid = 1'b0;
    wait_drain("t4_p3");
    tbl.delete();
    tbl.push_back('{din: 16'hFFFD, exp: 16'hFFFF});
    tbl.push_back('{din: 16'h0001, exp: 16'h0001});
    tbl.push_back('{din: 16'hFFFF, exp: 16'h0000});
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("t4_rnd%0d", i));

    // backpressure, dropped samples and overrun
    do_reset();
    out_ready = 1'b0;
    sb_q.push_back(16'h0100);
    send(16'h0100);
    n = 0;
    while (!out_valid1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_hold_valid", out_valid1, 1);
    wcoef(4'd0, 16'h0000);
    send(16'h0777);
    repeat (2) @(posedge clk);
    #1;
    check("t5_overrun_set", overrun1, 1);
    check("t5_data_held", out_data1, 16'h0100);
    check("t5_valid_held", out_valid1, 1);
    @(posedge clk); #1;
    overrun_clr = 1'b1; in_data = 16'h0555; in_valid = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0; in_valid = 1'b0;
    check("t5_set_wins", overrun1, 1);
    out_ready = 1'b1;
    wait_drain("t5_release");
    @(posedge clk); #1;
    check("t5_valid_after", out_valid1, 0);
    @(posedge clk); #1;
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    check("t5_overrun_clr", overrun1, 0);
    wcoef(4'd1, 16'h4000);
    run_vec('{din: 16'h0010, exp: 16'h0110}, "t5_history");

    // reset during MAC
    do_reset();
    wcoef(4'd0, 16'h2000);
    wcoef(4'd1, 16'h4000);
    send(16'h0200);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid1) seen = 1'b1;
    end
    check("t6_aborted", seen, 0);
    run_vec('{din: 16'h1234, exp: 16'h1234}, "t6_identity");

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
